// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The timeout default bounds how long a transfer may stall on the shared port.
package mem_arb_pkg;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts stalled BUSY cycles. expired flags the edge at which the count reaches TIMEOUT,
// so the arbiter leaves BUSY after exactly TIMEOUT unanswered cycles.
module mem_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expired = enable && !clear && (count_d == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Minimum latency: request -> mem_valid next cycle -> ack one cycle after mem_ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        core_stall,
    output logic        bus_error
);

    state_t      state_q,     state_d;
    req_id_t     last_q,      last_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] dm_rdata_q,  dm_rdata_d;
    logic        bus_error_q, bus_error_d;

    logic        grant;
    req_id_t     grant_id;
    logic        expired;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_error_d = bus_error_q;
        grant       = 1'b0;
        grant_id    = last_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant = 1'b1;
                    // On conflict, the side that did not win last time goes first.
                    if (if_req && dm_req) begin
                        grant_id = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
                    end else begin
                        grant_id = dm_req ? REQ_DM : REQ_IF;
                    end
                    last_d  = grant_id;
                    state_d = ST_BUSY;
                    if (grant_id == REQ_DM) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_wstrb_d = dm_wstrb;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (last_q == REQ_DM) dm_rdata_d = mem_rdata;
                    else                  if_rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else if (expired) begin
                    if (last_q == REQ_DM) dm_rdata_d = '0;
                    else                  if_rdata_d = '0;
                    bus_error_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            last_q      <= REQ_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (grant),
        .enable  ((state_q == ST_BUSY) && !mem_ready),
        .expired (expired)
    );

    assign mem_valid  = (state_q == ST_BUSY);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign if_ack     = (state_q == ST_RESP) && (last_q == REQ_IF);
    assign dm_ack     = (state_q == ST_RESP) && (last_q == REQ_DM);
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign bus_error  = bus_error_q;
    assign core_stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a short timeout so the abort path is reachable.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        core_stall;
    logic        bus_error;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_wstrb   (dm_wstrb),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .core_stall (core_stall),
        .bus_error  (bus_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_valid"}, 32'(mem_valid), 32'h0);
        chk({tag, " if_ack"},    32'(if_ack),    32'h0);
        chk({tag, " dm_ack"},    32'(dm_ack),    32'h0);
        chk({tag, " bus_error"}, 32'(bus_error), 32'h0);
        chk({tag, " mem_we"},    32'(mem_we),    32'h0);
        chk({tag, " mem_addr"},  mem_addr,       32'h0);
        chk({tag, " mem_wdata"}, mem_wdata,      32'h0);
        chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        chk({tag, " if_rdata"},  if_rdata,       32'h0);
        chk({tag, " dm_rdata"},  dm_rdata,       32'h0);
    endtask

    initial begin
        resetn = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
        chk("reset core_stall", 32'(core_stall), 32'h0);

        // Lone fetch at minimum latency.
        resetn = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        #1 chk("fetch stall c0", 32'(core_stall), 32'h1);
        tick();
        chk("fetch mem_valid c1", 32'(mem_valid), 32'h1);
        chk("fetch mem_addr c1",  mem_addr,       32'h100);
        chk("fetch mem_we c1",    32'(mem_we),    32'h0);
        chk("fetch mem_wstrb c1", 32'(mem_wstrb), 32'h0);
        chk("fetch if_ack c1",    32'(if_ack),    32'h0);
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
        #1;
        chk("fetch if_ack c2",    32'(if_ack),    32'h1);
        chk("fetch dm_ack c2",    32'(dm_ack),    32'h0);
        chk("fetch if_rdata c2",  if_rdata,       32'h00500093);
        chk("fetch mem_valid c2", 32'(mem_valid), 32'h0);
        chk("fetch stall at ack", 32'(core_stall), 32'h0);
        if_req = 1'b0;
        tick();
        chk("fetch if_ack c3",    32'(if_ack),    32'h0);
        chk("fetch rdata hold",   if_rdata,       32'h00500093);

        // Simultaneous requests straight after reset: DM wins, then IF.
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
        if_req = 1'b1; if_addr = 32'h104;
        tick();
        chk("conflict mem_addr DM",  mem_addr,       32'h2000);
        chk("conflict mem_we DM",    32'(mem_we),    32'h1);
        chk("conflict mem_wdata DM", mem_wdata,      32'hDEADBEEF);
        chk("conflict mem_wstrb DM", 32'(mem_wstrb), 32'hF);
        chk("conflict mem_valid DM", 32'(mem_valid), 32'h1);
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ready = 1'b0;
        chk("conflict dm_ack",       32'(dm_ack), 32'h1);
        chk("conflict if_ack early", 32'(if_ack), 32'h0);
        dm_req = 1'b0;
        #1 chk("conflict stall IF pending", 32'(core_stall), 32'h1);
        tick();
        chk("conflict dm_ack once", 32'(dm_ack), 32'h0);
        chk("conflict idle valid",  32'(mem_valid), 32'h0);
        tick();
        chk("conflict mem_addr IF", mem_addr,    32'h104);
        chk("conflict mem_we IF",   32'(mem_we), 32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        chk("conflict if_ack",       32'(if_ack), 32'h1);
        chk("conflict dm_ack IF",    32'(dm_ack), 32'h0);
        chk("conflict if_rdata",     if_rdata,    32'hCAFEF00D);
        chk("conflict dm_rdata hold", dm_rdata,   32'h11111111);
        if_req = 1'b0;
        tick();
        chk("conflict if_ack once", 32'(if_ack), 32'h0);

        // Variable latency: ready after 5 stalled cycles, inputs scrambled meanwhile.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_wdata = 32'h12345678; dm_wstrb = 4'h0;
        tick();
        dm_addr = 32'hFFFF0000; dm_wdata = 32'h0BADF00D;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("latency mem_valid",  32'(mem_valid),  32'h1);
            chk("latency mem_addr",   mem_addr,        32'h3000);
            chk("latency mem_wdata",  mem_wdata,       32'h12345678);
            chk("latency core_stall", 32'(core_stall), 32'h1);
            chk("latency dm_ack",     32'(dm_ack),     32'h0);
            tick();
        end
        mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ready = 1'b0;
        chk("latency dm_ack",   32'(dm_ack), 32'h1);
        chk("latency dm_rdata", dm_rdata,    32'hA5A5A5A5);
        dm_req = 1'b0;
        tick();

        // Requester drops its request mid-transfer; the ack still arrives.
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        if_req = 1'b0;
        #1 chk("drop core_stall", 32'(core_stall), 32'h0);
        tick();
        chk("drop mem_valid", 32'(mem_valid), 32'h1);
        mem_ready = 1'b1; mem_rdata = 32'h00000077;
        tick();
        mem_ready = 1'b0;
        chk("drop if_ack",   32'(if_ack), 32'h1);
        chk("drop if_rdata", if_rdata,    32'h00000077);
        tick();

        // Timeout: memory never answers.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000; dm_wdata = '0; dm_wstrb = '0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk("timeout mem_valid", 32'(mem_valid), 32'h1);
            chk("timeout dm_ack",    32'(dm_ack),    32'h0);
            chk("timeout bus_error", 32'(bus_error), 32'h0);
            tick();
        end
        chk("timeout dm_ack",    32'(dm_ack),    32'h1);
        chk("timeout mem_valid", 32'(mem_valid), 32'h0);
        chk("timeout dm_rdata",  dm_rdata,       32'h0);
        chk("timeout bus_error", 32'(bus_error), 32'h1);
        dm_req = 1'b0;
        tick();
        chk("timeout ack once", 32'(dm_ack), 32'h0);
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h00000055;
        tick();
        mem_ready = 1'b0; if_req = 1'b0;
        chk("sticky if_ack",    32'(if_ack),    32'h1);
        chk("sticky bus_error", 32'(bus_error), 32'h1);
        tick();
        chk("sticky bus_error idle", 32'(bus_error), 32'h1);

        // Reset during BUSY abandons the transfer.
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        chk("midreset mem_valid before", 32'(mem_valid), 32'h1);
        resetn = 1'b0; if_req = 1'b0;
        tick();
        chk_reset_outputs("midreset");
        resetn = 1'b1;
        tick();
        chk("midreset no late if_ack", 32'(if_ack),    32'h0);
        chk("midreset idle valid",     32'(mem_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
